// File: rtl/mem_dump_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_dump_ctrl_pkg
//   Shared definitions for the memory dump sequencer.
//   - Default memory geometry (16 words x 8 bits). The block-RAM instance and
//     the dump controller both take their widths from here so they agree.
//   - State type for the dump sequencer FSM.
// ---------------------------------------------------------------------------
package mem_dump_ctrl_pkg;

  // Default geometry of the block-RAM being dumped.
  localparam int unsigned MEM_ADDR_WIDTH = 4;
  localparam int unsigned MEM_DATA_WIDTH = 8;

  // Sequencer states:
  //   ST_IDLE  : waiting for a start pulse
  //   ST_READ  : read strobe is on the memory port for this one cycle
  //   ST_LATCH : memory data is valid, capture it into the output register
  //   ST_SEND  : byte offered downstream, waiting for acceptance
  //   ST_DONE  : one-cycle completion pulse, then back to idle
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } dump_state_e;

endpackage : mem_dump_ctrl_pkg

// File: rtl/mem_dump_ctrl.sv
// ---------------------------------------------------------------------------
// mem_dump_ctrl
//   Read-side sequencer for the block-RAM. A start pulse launches a sweep of
//   the read address from 0 to LAST_ADDR, one read strobe per word. Each word
//   returned by the memory (one cycle after the strobe) is captured and
//   offered downstream over a valid/ready handshake. The next word is only
//   read once the current byte has been accepted, so a stalled consumer
//   simply freezes the sweep.
//
// Parameters
//   ADDR_WIDTH  memory address width
//   DATA_WIDTH  memory word width
//   LAST_ADDR   final address read in a sweep (inclusive)
//
// Ports
//   clk_i       system clock, rising edge
//   rst_i       synchronous active-high reset
//   start_i     begin a sweep (only looked at while idle)
//   r_en_o      memory read enable (registered)
//   r_addr_o    memory read address (registered)
//   r_data_i    memory read data, valid one cycle after r_en_o
//   tx_data_o   byte offered downstream, stable while tx_valid_o is high
//   tx_valid_o  tx_data_o holds a byte awaiting acceptance
//   tx_ready_i  downstream accepts on tx_valid_o && tx_ready_i
//   busy_o      high from the cycle after start until the done cycle ends
//   done_o      one-cycle pulse after the last byte has been accepted
// ---------------------------------------------------------------------------
module mem_dump_ctrl
  import mem_dump_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int unsigned LAST_ADDR  = (2 ** ADDR_WIDTH) - 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  r_en_o,
  output logic [ADDR_WIDTH-1:0] r_addr_o,
  input  logic [DATA_WIDTH-1:0] r_data_i,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  // Final address of the sweep, sized to the address bus.
  localparam logic [ADDR_WIDTH-1:0] LastAddrC = ADDR_WIDTH'(LAST_ADDR);

  dump_state_e           state_q,    state_d;
  logic                  r_en_q,     r_en_d;
  logic [ADDR_WIDTH-1:0] r_addr_q,   r_addr_d;
  logic [DATA_WIDTH-1:0] tx_data_q,  tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;

  logic                  at_last;
  logic                  accept;

  // The address is compared before it would be incremented, so a sweep that
  // ends at the top of the address space never wraps back to zero; the last
  // address is simply left on the bus until the next start.
  assign at_last = (r_addr_q == LastAddrC);

  // A byte leaves only when it is actually being offered; a ready seen while
  // nothing is valid has no effect.
  assign accept = tx_valid_q && tx_ready_i;

  // Next-state and next-output logic. Every output is a register, so this
  // block decides what each register holds after the coming edge. Anything
  // not mentioned in a state keeps its value, which is what keeps tx_data
  // frozen and the read strobe off while the consumer stalls.
  always_comb begin
    state_d    = state_q;
    r_en_d     = r_en_q;
    r_addr_d   = r_addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = done_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          r_addr_d = '0;
          r_en_d   = 1'b1;
          busy_d   = 1'b1;
          state_d  = ST_READ;
        end
      end

      ST_READ: begin
        // The strobe is a single-cycle pulse; the memory answers next cycle.
        r_en_d  = 1'b0;
        state_d = ST_LATCH;
      end

      ST_LATCH: begin
        tx_data_d  = r_data_i;
        tx_valid_d = 1'b1;
        state_d    = ST_SEND;
      end

      ST_SEND: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          if (at_last) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            r_addr_d = r_addr_q + ADDR_WIDTH'(1);
            r_en_d   = 1'b1;
            state_d  = ST_READ;
          end
        end
      end

      ST_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        r_en_d     = 1'b0;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset abandons any sweep in progress and
  // drops a byte that was still waiting for acceptance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      r_en_q     <= 1'b0;
      r_addr_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_en_q     <= r_en_d;
      r_addr_q   <= r_addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign r_en_o     = r_en_q;
  assign r_addr_o   = r_addr_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule : mem_dump_ctrl

// File: tb/tb_mem_dump_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_dump_ctrl
//   Drives two controllers (full 16-word sweep and a 4-word sweep) each in
//   front of a simple behavioural memory. Bytes seen leaving the handshake are
//   compared with the memory contents read in address order.
// ---------------------------------------------------------------------------
module tb_mem_dump_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Full-range controller
  logic          start_a, ready_a;
  logic          r_en_a, valid_a, busy_a, done_a;
  logic [AW-1:0] r_addr_a;
  logic [DW-1:0] r_data_a, tx_data_a;

  // Short-sweep controller (LAST_ADDR = 3)
  logic          start_b, ready_b;
  logic          r_en_b, valid_b, busy_b, done_b;
  logic [AW-1:0] r_addr_b;
  logic [DW-1:0] r_data_b, tx_data_b;

  logic [DW-1:0] mem [16];

  mem_dump_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_a),
    .r_en_o(r_en_a), .r_addr_o(r_addr_a), .r_data_i(r_data_a),
    .tx_data_o(tx_data_a), .tx_valid_o(valid_a), .tx_ready_i(ready_a),
    .busy_o(busy_a), .done_o(done_a)
  );

  mem_dump_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LAST_ADDR(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .start_i(start_b),
    .r_en_o(r_en_b), .r_addr_o(r_addr_b), .r_data_i(r_data_b),
    .tx_data_o(tx_data_b), .tx_valid_o(valid_b), .tx_ready_i(ready_b),
    .busy_o(busy_b), .done_o(done_b)
  );

  // Behavioural synchronous-read memories: data one cycle after the strobe.
  always @(posedge clk) if (r_en_a) r_data_a <= mem[r_addr_a];
  always @(posedge clk) if (r_en_b) r_data_b <= mem[r_addr_b];

  // Observation mux so the sweep collector can watch either controller.
  logic          sel3;
  logic          o_en, o_valid, o_busy, o_done;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  always_comb begin
    o_en    = sel3 ? r_en_b    : r_en_a;
    o_valid = sel3 ? valid_b   : valid_a;
    o_busy  = sel3 ? busy_b    : busy_a;
    o_done  = sel3 ? done_b    : done_a;
    o_addr  = sel3 ? r_addr_b  : r_addr_a;
    o_data  = sel3 ? tx_data_b : tx_data_a;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the most recent sweep
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  int  en_high, en_rises, done_cnt, stall_viol, busy_gap;
  int  first_lat, done_cycle;
  bit  timeout;
  bit  post_busy [4];
  bit  post_en   [4];

  // Reference model: a sweep emits the memory words 0..last in address order.
  function automatic void build_expected(input int last);
    exp_q.delete();
    for (int i = 0; i <= last; i++) exp_q.push_back(mem[i]);
  endfunction

  task automatic drive_start(input bit use3, input bit v);
    if (use3) start_b = v; else start_a = v;
  endtask

  task automatic drive_ready(input bit use3, input bit v);
    if (use3) ready_b = v; else ready_a = v;
  endtask

  task automatic apply_reset();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one sweep and records what came out of the handshake.
  // mode 0: ready always high; 1: random ready; 2: ready low for the first
  // 20 cycles a byte is offered, then high.
  task automatic run_sweep(input bit use3, input int mode, input int restart_at,
                           input bit hold_start, input int budget);
    bit            prev_pending, prev_en, restarted, done_seen, rdy, rs;
    logic [DW-1:0] prev_data;
    int            post, stall_left;
    sel3 = use3;
    got_q.delete();
    en_high = 0; en_rises = 0; done_cnt = 0; stall_viol = 0; busy_gap = 0;
    first_lat = -1; done_cycle = -1; timeout = 1'b1;
    prev_pending = 1'b0; prev_en = 1'b0; restarted = 1'b0; done_seen = 1'b0;
    prev_data = '0; post = 0; stall_left = 20;
    for (int k = 0; k < 4; k++) begin post_busy[k] = 1'b0; post_en[k] = 1'b0; end
    @(negedge clk);
    drive_start(use3, 1'b1);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      rs = !restarted && (restart_at >= 0) && (got_q.size() == restart_at);
      if (rs) restarted = 1'b1;
      drive_start(use3, hold_start || rs);
      if (o_en) en_high++;
      if (o_en && !prev_en) en_rises++;
      prev_en = o_en;
      if (o_valid && first_lat < 0) first_lat = c;
      if (prev_pending && (!o_valid || o_data !== prev_data || o_en)) stall_viol++;
      if (!done_seen && !o_busy) busy_gap++;
      if (done_seen) begin
        post_busy[post] = o_busy;
        post_en[post]   = o_en;
        post++;
      end
      if (o_done) begin
        done_cnt++;
        if (!done_seen) begin done_seen = 1'b1; done_cycle = c; end
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: begin
          if (o_valid && stall_left > 0) begin rdy = 1'b0; stall_left--; end
          else rdy = 1'b1;
        end
      endcase
      drive_ready(use3, rdy);
      if (o_valid && rdy && !done_seen) got_q.push_back(o_data);
      prev_pending = o_valid && !rdy;
      prev_data    = o_data;
      if (post == 4) begin timeout = 1'b0; break; end
    end
    drive_start(use3, 1'b0);
    drive_ready(use3, 1'b0);
  endtask

  task automatic test_reset();
    int en_seen;
    apply_reset();
    @(negedge clk);
    n_checks++;
    if ({r_en_a, valid_a, busy_a, done_a} !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL reset_ctrl: got en/valid/busy/done=%b expected 0000", {r_en_a, valid_a, busy_a, done_a});
    end
    n_checks++;
    if (r_addr_a !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h expected 0", r_addr_a); end
    n_checks++;
    if (tx_data_a !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_data: got %h expected 00", tx_data_a); end
    n_checks++;
    if ({r_en_b, valid_b, busy_b, done_b, r_addr_b, tx_data_b} !== 16'h0000) begin
      n_fail++; $display("[TB] FAIL reset_dut3: got %h expected 0000", {r_en_b, valid_b, busy_b, done_b, r_addr_b, tx_data_b});
    end
    en_seen = 0;
    repeat (10) begin @(negedge clk); if (r_en_a || r_en_b || busy_a) en_seen++; end
    n_checks++;
    if (en_seen !== 0) begin n_fail++; $display("[TB] FAIL idle_quiet: got %0d active cycles expected 0", en_seen); end
  endtask

  task automatic test_full_sweep();
    build_expected(15);
    run_sweep(1'b0, 0, -1, 1'b0, 200);
    n_checks++;
    if (timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL full_timeout: got %0d expected 0", timeout); end
    n_checks++;
    if (got_q.size() !== 16) begin n_fail++; $display("[TB] FAIL full_count: got %0d expected 16", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL full_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++;
    if (first_lat !== 3) begin n_fail++; $display("[TB] FAIL full_latency: got %0d expected 3", first_lat); end
    n_checks++;
    if (done_cycle !== 49) begin n_fail++; $display("[TB] FAIL full_done_cycle: got %0d expected 49", done_cycle); end
    n_checks++;
    if (en_rises !== 16 || en_high !== 16) begin
      n_fail++; $display("[TB] FAIL full_ren: got %0d pulses %0d high cycles expected 16/16", en_rises, en_high);
    end
    n_checks++;
    if (done_cnt !== 1) begin n_fail++; $display("[TB] FAIL full_done_cnt: got %0d expected 1", done_cnt); end
    n_checks++;
    if (busy_gap !== 0 || post_busy[0] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL full_busy: got gap %0d after %0d expected 0/0", busy_gap, post_busy[0]);
    end
    n_checks++;
    if (r_addr_a !== 4'hF) begin n_fail++; $display("[TB] FAIL full_last_addr: got %h expected f", r_addr_a); end
  endtask

  task automatic test_stall();
    build_expected(15);
    run_sweep(1'b0, 2, -1, 1'b0, 300);
    n_checks++;
    if (timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_timeout: got %0d expected 0", timeout); end
    n_checks++;
    if (stall_viol !== 0) begin n_fail++; $display("[TB] FAIL stall_hold: got %0d violations expected 0", stall_viol); end
    n_checks++;
    if (got_q.size() < 2 || got_q[0] !== 8'h10 || got_q[1] !== 8'h11) begin
      n_fail++; $display("[TB] FAIL stall_first_bytes: got %0d bytes, expected 10 then 11", got_q.size());
    end
    n_checks++;
    if (done_cycle !== 69) begin n_fail++; $display("[TB] FAIL stall_done_cycle: got %0d expected 69", done_cycle); end
    n_checks++;
    if (en_rises !== 16 || done_cnt !== 1) begin
      n_fail++; $display("[TB] FAIL stall_counts: got %0d pulses %0d done expected 16/1", en_rises, done_cnt);
    end
  endtask

  task automatic test_restart_ignored();
    build_expected(15);
    run_sweep(1'b0, 0, 5, 1'b0, 200);
    n_checks++;
    if (got_q.size() !== 16) begin n_fail++; $display("[TB] FAIL restart_count: got %0d expected 16", got_q.size()); end
    n_checks++;
    if (got_q.size() == 16 && got_q !== exp_q) begin n_fail++; $display("[TB] FAIL restart_sequence: byte order differs from memory"); end
    n_checks++;
    if (done_cnt !== 1 || en_high !== 16) begin
      n_fail++; $display("[TB] FAIL restart_counts: got %0d done %0d reads expected 1/16", done_cnt, en_high);
    end
    n_checks++;
    if (done_cycle !== 49) begin n_fail++; $display("[TB] FAIL restart_done_cycle: got %0d expected 49", done_cycle); end
  endtask

  task automatic test_back_to_back();
    build_expected(15);
    run_sweep(1'b0, 0, -1, 1'b1, 200);
    n_checks++;
    if (got_q.size() !== 16 || done_cnt !== 1) begin
      n_fail++; $display("[TB] FAIL b2b_first: got %0d bytes %0d done expected 16/1", got_q.size(), done_cnt);
    end
    n_checks++;
    if (post_busy[0] !== 1'b0 || post_en[0] !== 1'b0) begin
      n_fail++; $display("[TB] FAIL b2b_idle_cycle: got busy %0d en %0d expected 0/0", post_busy[0], post_en[0]);
    end
    n_checks++;
    if (post_en[1] !== 1'b1 || post_busy[1] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL b2b_restart: got en %0d busy %0d expected 1/1", post_en[1], post_busy[1]);
    end
    apply_reset();
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    sel3 = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (valid_a && r_addr_a == 4'd7) begin
        ready_a = 1'b0; rst = 1'b1; found = 1'b1;
        break;
      end
      ready_a = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (found !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_reach: got %0d expected 1", found); end
    n_checks++;
    if ({valid_a, busy_a, r_en_a, done_a} !== 4'b0000 || r_addr_a !== 4'h0) begin
      n_fail++; $display("[TB] FAIL midreset_clear: got valid/busy/en/done=%b addr=%h expected 0000/0", {valid_a, busy_a, r_en_a, done_a}, r_addr_a);
    end
    build_expected(15);
    run_sweep(1'b0, 0, -1, 1'b0, 200);
    n_checks++;
    if (got_q.size() !== 16 || got_q[0] !== 8'h10) begin
      n_fail++; $display("[TB] FAIL midreset_resweep: got %0d bytes expected 16 starting at 10", got_q.size());
    end
  endtask

  task automatic test_short_sweep();
    build_expected(3);
    run_sweep(1'b1, 0, -1, 1'b0, 100);
    n_checks++;
    if (got_q.size() !== 4) begin n_fail++; $display("[TB] FAIL short_count: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL short_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++;
    if (done_cnt !== 1 || done_cycle !== 13) begin
      n_fail++; $display("[TB] FAIL short_done: got %0d pulses at %0d expected 1 at 13", done_cnt, done_cycle);
    end
    n_checks++;
    if (r_addr_b !== 4'd3) begin n_fail++; $display("[TB] FAIL short_last_addr: got %h expected 3", r_addr_b); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      bit use3;
      int last;
      use3 = (it == 3);
      last = use3 ? 3 : 15;
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      build_expected(last);
      run_sweep(use3, 1, -1, 1'b0, 600);
      n_checks++;
      if (timeout !== 1'b0 || got_q.size() !== last + 1) begin
        n_fail++; $display("[TB] FAIL rand%0d_count: got %0d bytes timeout %0d expected %0d/0", it, got_q.size(), timeout, last + 1);
      end
      n_checks++;
      if (got_q.size() == last + 1 && got_q !== exp_q) begin
        n_fail++; $display("[TB] FAIL rand%0d_sequence: byte stream differs from memory contents", it);
      end
      n_checks++;
      if (stall_viol !== 0 || en_rises !== last + 1 || en_high !== last + 1 || done_cnt !== 1) begin
        n_fail++; $display("[TB] FAIL rand%0d_protocol: got viol %0d pulses %0d high %0d done %0d expected 0/%0d/%0d/1",
                           it, stall_viol, en_rises, en_high, done_cnt, last + 1, last + 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0; sel3 = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    test_reset();
    test_full_sweep();
    test_stall();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid();
    test_short_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_dump_ctrl
